id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-delivery stage that directly feeds the ALU.
- Captures decoded instruction fields and control from ID. Decodes ALU function code F[2:0] from aluop/funct at capture time.
- Drives ALU operands A/B through EX/MEM and MEM/WB forwarding muxes.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
N, 32, datapath width
R, 5, register-index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  hold all ID/EX registers this edge
flush  in  1  load a bubble this edge (priority over stall)
id_rd1  in  N  register-file read data for rs
id_rd2  in  N  register-file read data for rt
id_signimm  in  N  sign-extended immediate
id_rs  in  R  source register index rs
id_rt  in  R  source register index rt
id_rd  in  R  destination register index rd
id_regwrite  in  1  control: write register file
id_memtoreg  in  1  control: writeback from memory
id_memwrite  in  1  control: store
id_alusrc  in  1  control: ALU B = immediate
id_regdst  in  1  control: destination is rd (else rt)
id_aluop  in  2  main-decoder ALU op class
id_funct  in  6  instruction funct field
exm_regwrite  in  1  EX/MEM regwrite
exm_rd  in  R  EX/MEM destination index
exm_result  in  N  EX/MEM ALU result
wb_regwrite  in  1  MEM/WB regwrite
wb_rd  in  R  MEM/WB destination index
wb_result  in  N  MEM/WB writeback value
alu_a  out  N  ALU operand A (combinational)
alu_b  out  N  ALU operand B (combinational)
alu_f  out  3  ALU function code (registered)
ex_writedata  out  N  forwarded rt value, for stores
ex_writereg  out  R  selected destination index
ex_rs  out  R  registered rs, for the hazard unit
ex_rt  out  R  registered rt, for the hazard unit
ex_regwrite  out  1  registered control
ex_memtoreg  out  1  registered control; the hazard unit uses it for load-use detection
ex_memwrite  out  1  registered control

Behaviour:
- Register file: rd1_q, rd2_q, imm_q, rs_q, rt_q, rd_q, regwrite_q, memtoreg_q, memwrite_q, alusrc_q, regdst_q, f_q.
- Reset, asynchronous: every register goes to 0 immediately, except f_q, which goes to 3'b010 (add). All registered outputs reflect these values. alu_a/alu_b then equal 0 unless forwarding matches index 0; it cannot, per the rules below.
- Each rising clk, reset low, one of three cases applies:
  - flush=1: bubble. All registers loaded as at reset, regardless of stall.
  - flush=0, stall=1: all registers hold their values.
  - otherwise: capture all id_* inputs. f_q captures the decoded code.
- ALU decode, from id_aluop and id_funct:
  - aluop 00 -> 010 (add, lw/sw/addi)
  - aluop 01 -> 110 (sub, beq)
  - aluop 11 -> 010
  - aluop 10 uses funct: 100000 -> 010 add; 100010 -> 110 sub; 100100 -> 000 and; 100101 -> 001 or; 101010 -> 111 slt.
  - Any other funct -> 010.
- Forwarding for operand A, combinational:
  - If exm_regwrite and exm_rd != 0 and exm_rd == rs_q: exm_result.
  - Else if wb_regwrite and wb_rd != 0 and wb_rd == rs_q: wb_result.
  - Else: rd1_q.
  - EX/MEM wins when both stages match.
- Forwarding for ex_writedata: same rule using rt_q and rd2_q.
- alu_b = alusrc_q ? imm_q : ex_writedata.
- ex_writereg = regdst_q ? rd_q : rt_q.
- Latency: ID values appear on the outputs one cycle after capture. Forwarded values pass through with zero latency.
- Register 0 is never forwarded, even when regwrite=1.
- Reset asserted mid-stall or mid-flush overrides both immediately.

Test Plan:
1. Reset: assert reset with nonzero inputs -> all outputs 0, alu_f=010. Deassert, capture id_rd1=5, id_rd2=7, aluop=10, funct=100010 -> next cycle alu_a=5, alu_b=7, alu_f=110.
2. Decode sweep: aluop=10 with funct 100000/100100/100101/101010/000000 -> alu_f 010/000/001/111/010. aluop 00 -> 010; aluop 01 -> 110.
3. Forwarding priority: rs_q=3, exm(rw=1, rd=3, result=0xAA), wb(rw=1, rd=3, result=0xBB) -> alu_a=0xAA. Drop exm_regwrite -> alu_a=0xBB. rs_q=0 with exm_rd=0, rw=1 -> alu_a=rd1_q.
4. alusrc/regdst: alusrc=1, imm=0xFFFFFFFC, rt_q matches exm_rd -> alu_b=0xFFFFFFFC and ex_writedata=exm_result. regdst=1, rd=9, rt=4 -> ex_writereg=9; regdst=0 -> 4.
5. Stall vs flush: capture A, then stall=1 for 2 cycles with changing id_* inputs -> outputs unchanged. Stall=1 and flush=1 together -> ex_regwrite=0, ex_memwrite=0, ex_memtoreg=0, alu_f=010.
6. Async reset mid-operation: pulse reset between clock edges while holding a stall -> outputs clear before the next edge. Capture resumes on the first edge after deassertion.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and ALU operand-delivery stage.
// Holds the decoded instruction for one cycle and forwards fresher EX/MEM
// or MEM/WB results onto the ALU operands and the store data.
module id_ex_stage #(
    parameter int N = 32,
    parameter int R = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         flush,
    input  logic [N-1:0] id_rd1,
    input  logic [N-1:0] id_rd2,
    input  logic [N-1:0] id_signimm,
    input  logic [R-1:0] id_rs,
    input  logic [R-1:0] id_rt,
    input  logic [R-1:0] id_rd,
    input  logic         id_regwrite,
    input  logic         id_memtoreg,
    input  logic         id_memwrite,
    input  logic         id_alusrc,
    input  logic         id_regdst,
    input  logic [1:0]   id_aluop,
    input  logic [5:0]   id_funct,
    input  logic         exm_regwrite,
    input  logic [R-1:0] exm_rd,
    input  logic [N-1:0] exm_result,
    input  logic         wb_regwrite,
    input  logic [R-1:0] wb_rd,
    input  logic [N-1:0] wb_result,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_f,
    output logic [N-1:0] ex_writedata,
    output logic [R-1:0] ex_writereg,
    output logic [R-1:0] ex_rs,
    output logic [R-1:0] ex_rt,
    output logic         ex_regwrite,
    output logic         ex_memtoreg,
    output logic         ex_memwrite
);

    localparam logic [2:0] F_ADD = 3'b010;
    localparam logic [2:0] F_SUB = 3'b110;
    localparam logic [2:0] F_AND = 3'b000;
    localparam logic [2:0] F_OR  = 3'b001;
    localparam logic [2:0] F_SLT = 3'b111;

    logic [N-1:0] r_rd1;
    logic [N-1:0] r_rd2;
    logic [N-1:0] r_imm;
    logic [R-1:0] r_rs;
    logic [R-1:0] r_rt;
    logic [R-1:0] r_rd;
    logic         r_regwrite;
    logic         r_memtoreg;
    logic         r_memwrite;
    logic         r_alusrc;
    logic         r_regdst;
    logic [2:0]   r_f;

    logic [2:0]   w_f_dec;
    logic [N-1:0] w_fwd_a;
    logic [N-1:0] w_fwd_b;

    // ALU function decode from the main-decoder op class and funct field
    always_comb begin
        w_f_dec = F_ADD;
        case (id_aluop)
            2'b01: w_f_dec = F_SUB;
            2'b10: begin
                case (id_funct)
                    6'b100000: w_f_dec = F_ADD;
                    6'b100010: w_f_dec = F_SUB;
                    6'b100100: w_f_dec = F_AND;
                    6'b100101: w_f_dec = F_OR;
                    6'b101010: w_f_dec = F_SLT;
                    default:   w_f_dec = F_ADD;
                endcase
            end
            default: w_f_dec = F_ADD;
        endcase
    end

    // Pipeline register: flush inserts a bubble (beats stall), stall holds
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_imm      <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_memwrite <= 1'b0;
            r_alusrc   <= 1'b0;
            r_regdst   <= 1'b0;
            r_f        <= F_ADD;
        end else if (flush) begin
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_imm      <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_memwrite <= 1'b0;
            r_alusrc   <= 1'b0;
            r_regdst   <= 1'b0;
            r_f        <= F_ADD;
        end else if (!stall) begin
            r_rd1      <= id_rd1;
            r_rd2      <= id_rd2;
            r_imm      <= id_signimm;
            r_rs       <= id_rs;
            r_rt       <= id_rt;
            r_rd       <= id_rd;
            r_regwrite <= id_regwrite;
            r_memtoreg <= id_memtoreg;
            r_memwrite <= id_memwrite;
            r_alusrc   <= id_alusrc;
            r_regdst   <= id_regdst;
            r_f        <= w_f_dec;
        end
    end

    // Operand forwarding; the younger EX/MEM result wins, register 0 is never forwarded
    always_comb begin
        w_fwd_a = r_rd1;
        w_fwd_b = r_rd2;
        if (exm_regwrite && (exm_rd != '0) && (exm_rd == r_rs)) begin
            w_fwd_a = exm_result;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == r_rs)) begin
            w_fwd_a = wb_result;
        end
        if (exm_regwrite && (exm_rd != '0) && (exm_rd == r_rt)) begin
            w_fwd_b = exm_result;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == r_rt)) begin
            w_fwd_b = wb_result;
        end
    end

    assign alu_a        = w_fwd_a;
    assign ex_writedata = w_fwd_b;
    assign alu_b        = r_alusrc ? r_imm : w_fwd_b;
    assign alu_f        = r_f;
    assign ex_writereg  = r_regdst ? r_rd : r_rt;
    assign ex_rs        = r_rs;
    assign ex_rt        = r_rt;
    assign ex_regwrite  = r_regwrite;
    assign ex_memtoreg  = r_memtoreg;
    assign ex_memwrite  = r_memwrite;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage with hand-computed expectations.
module tb_id_ex_stage;

    localparam int N = 32;
    localparam int R = 5;

    logic         clk;
    logic         reset;
    logic         stall;
    logic         flush;
    logic [N-1:0] id_rd1;
    logic [N-1:0] id_rd2;
    logic [N-1:0] id_signimm;
    logic [R-1:0] id_rs;
    logic [R-1:0] id_rt;
    logic [R-1:0] id_rd;
    logic         id_regwrite;
    logic         id_memtoreg;
    logic         id_memwrite;
    logic         id_alusrc;
    logic         id_regdst;
    logic [1:0]   id_aluop;
    logic [5:0]   id_funct;
    logic         exm_regwrite;
    logic [R-1:0] exm_rd;
    logic [N-1:0] exm_result;
    logic         wb_regwrite;
    logic [R-1:0] wb_rd;
    logic [N-1:0] wb_result;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [2:0]   alu_f;
    logic [N-1:0] ex_writedata;
    logic [R-1:0] ex_writereg;
    logic [R-1:0] ex_rs;
    logic [R-1:0] ex_rt;
    logic         ex_regwrite;
    logic         ex_memtoreg;
    logic         ex_memwrite;

    int compared;
    int mismatched;

    id_ex_stage #(.N(N), .R(R)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_signimm(id_signimm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg),
        .id_memwrite(id_memwrite), .id_alusrc(id_alusrc),
        .id_regdst(id_regdst), .id_aluop(id_aluop), .id_funct(id_funct),
        .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .ex_writedata(ex_writedata), .ex_writereg(ex_writereg),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_regwrite(ex_regwrite),
        .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] aluop, input logic [5:0] funct);
        id_aluop = aluop;
        id_funct = funct;
    endtask

    typedef struct {
        logic [1:0] aluop;
        logic [5:0] funct;
        logic [2:0] expF;
    } decVec_t;

    decVec_t decVecs[8];

    // Directed sequence
    initial begin
        compared   = 0;
        mismatched = 0;

        decVecs[0] = '{2'b10, 6'b100000, 3'b010};
        decVecs[1] = '{2'b10, 6'b100100, 3'b000};
        decVecs[2] = '{2'b10, 6'b100101, 3'b001};
        decVecs[3] = '{2'b10, 6'b101010, 3'b111};
        decVecs[4] = '{2'b10, 6'b000000, 3'b010};
        decVecs[5] = '{2'b00, 6'b100010, 3'b010};
        decVecs[6] = '{2'b01, 6'b100100, 3'b110};
        decVecs[7] = '{2'b11, 6'b100010, 3'b010};

        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        id_rd1 = 32'h1234; id_rd2 = 32'h5678; id_signimm = 32'h9;
        id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3;
        id_regwrite = 1'b1; id_memtoreg = 1'b1; id_memwrite = 1'b1;
        id_alusrc = 1'b0; id_regdst = 1'b1;
        applyStimulus(2'b10, 6'b100100);
        exm_regwrite = 1'b1; exm_rd = 5'd3; exm_result = 32'hAA;
        wb_regwrite = 1'b1; wb_rd = 5'd4; wb_result = 32'hBB;

        // Reset state, sampled while clock edges arrive under reset
        #3;
        tick();
        checkOutput("rst_alu_a", alu_a, 32'h0);
        checkOutput("rst_alu_b", alu_b, 32'h0);
        checkOutput("rst_alu_f", {29'd0, alu_f}, 32'h2);
        checkOutput("rst_wdata", ex_writedata, 32'h0);
        checkOutput("rst_wreg", {27'd0, ex_writereg}, 32'h0);
        checkOutput("rst_rs", {27'd0, ex_rs}, 32'h0);
        checkOutput("rst_ctrl", {29'd0, ex_regwrite, ex_memtoreg, ex_memwrite}, 32'h0);

        // First capture after reset
        reset = 1'b0;
        exm_regwrite = 1'b0; wb_regwrite = 1'b0;
        id_rd1 = 32'd5; id_rd2 = 32'd7; id_regwrite = 1'b0; id_memtoreg = 1'b0; id_memwrite = 1'b0;
        applyStimulus(2'b10, 6'b100010);
        #1;
        checkOutput("lat_alu_f", {29'd0, alu_f}, 32'h2);
        tick();
        checkOutput("cap_alu_a", alu_a, 32'd5);
        checkOutput("cap_alu_b", alu_b, 32'd7);
        checkOutput("cap_alu_f", {29'd0, alu_f}, 32'h6);
        checkOutput("cap_rs", {27'd0, ex_rs}, 32'd1);
        checkOutput("cap_rt", {27'd0, ex_rt}, 32'd2);

        // Decode sweep
        foreach (decVecs[i]) begin
            applyStimulus(decVecs[i].aluop, decVecs[i].funct);
            tick();
            checkOutput($sformatf("dec_%0d", i), {29'd0, alu_f}, {29'd0, decVecs[i].expF});
        end

        // Forwarding priority on operand A
        id_rs = 5'd3; id_rd1 = 32'h11; id_rt = 5'd2; id_rd2 = 32'h22;
        tick();
        exm_regwrite = 1'b1; exm_rd = 5'd3; exm_result = 32'hAA;
        wb_regwrite = 1'b1; wb_rd = 5'd3; wb_result = 32'hBB;
        #1;
        checkOutput("fwd_exm_wins", alu_a, 32'hAA);
        checkOutput("fwd_rt_nomatch", ex_writedata, 32'h22);
        exm_regwrite = 1'b0;
        #1;
        checkOutput("fwd_wb", alu_a, 32'hBB);
        wb_regwrite = 1'b0;
        #1;
        checkOutput("fwd_none", alu_a, 32'h11);
        id_rs = 5'd0; id_rd1 = 32'h33;
        tick();
        exm_regwrite = 1'b1; exm_rd = 5'd0; exm_result = 32'hAA;
        wb_regwrite = 1'b1; wb_rd = 5'd0; wb_result = 32'hBB;
        #1;
        checkOutput("fwd_reg0", alu_a, 32'h33);

        // Immediate select, store-data forwarding and destination select
        id_alusrc = 1'b1; id_signimm = 32'hFFFF_FFFC; id_rt = 5'd4; id_rd = 5'd9;
        id_rd2 = 32'h44; id_regdst = 1'b1;
        tick();
        exm_regwrite = 1'b1; exm_rd = 5'd4; exm_result = 32'hAA;
        wb_regwrite = 1'b0;
        #1;
        checkOutput("imm_alu_b", alu_b, 32'hFFFF_FFFC);
        checkOutput("wdata_exm", ex_writedata, 32'hAA);
        checkOutput("wreg_rd", {27'd0, ex_writereg}, 32'd9);
        exm_regwrite = 1'b0; wb_regwrite = 1'b1; wb_rd = 5'd4; wb_result = 32'hBB;
        #1;
        checkOutput("wdata_wb", ex_writedata, 32'hBB);
        wb_regwrite = 1'b0;
        id_regdst = 1'b0; id_alusrc = 1'b0;
        tick();
        checkOutput("wreg_rt", {27'd0, ex_writereg}, 32'd4);
        checkOutput("regb_alu_b", alu_b, 32'h44);

        // Stall holds everything, flush beats stall
        id_rd1 = 32'h100; id_rd2 = 32'h200; id_rs = 5'd6; id_rt = 5'd7; id_rd = 5'd8;
        id_regwrite = 1'b1; id_memtoreg = 1'b1; id_memwrite = 1'b1; id_regdst = 1'b1;
        applyStimulus(2'b10, 6'b100100);
        tick();
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            id_rd1 = 32'h900 + k; id_rd2 = 32'hA00 + k; id_rs = 5'd10 + k[4:0];
            id_rd = 5'd12; id_regwrite = 1'b0; id_memwrite = 1'b0;
            applyStimulus(2'b01, 6'b0);
            tick();
        end
        checkOutput("stall_alu_a", alu_a, 32'h100);
        checkOutput("stall_alu_b", alu_b, 32'h200);
        checkOutput("stall_alu_f", {29'd0, alu_f}, 32'h0);
        checkOutput("stall_wreg", {27'd0, ex_writereg}, 32'd8);
        checkOutput("stall_rs", {27'd0, ex_rs}, 32'd6);
        checkOutput("stall_ctrl", {29'd0, ex_regwrite, ex_memtoreg, ex_memwrite}, 32'h7);
        flush = 1'b1;
        tick();
        checkOutput("flush_ctrl", {29'd0, ex_regwrite, ex_memtoreg, ex_memwrite}, 32'h0);
        checkOutput("flush_alu_f", {29'd0, alu_f}, 32'h2);
        checkOutput("flush_alu_a", alu_a, 32'h0);

        // Asynchronous reset between edges while stalled
        flush = 1'b0; stall = 1'b0;
        id_rd1 = 32'h100; id_rs = 5'd6; id_regwrite = 1'b1; id_memtoreg = 1'b1; id_memwrite = 1'b1;
        applyStimulus(2'b10, 6'b100101);
        tick();
        checkOutput("pre_rst_ctrl", {29'd0, ex_regwrite, ex_memtoreg, ex_memwrite}, 32'h7);
        stall = 1'b1;
        #1 reset = 1'b1;
        #1;
        checkOutput("async_alu_a", alu_a, 32'h0);
        checkOutput("async_ctrl", {29'd0, ex_regwrite, ex_memtoreg, ex_memwrite}, 32'h0);
        checkOutput("async_alu_f", {29'd0, alu_f}, 32'h2);
        #1 reset = 1'b0;
        stall = 1'b0;
        id_rd1 = 32'h77; applyStimulus(2'b10, 6'b101010);
        tick();
        checkOutput("resume_alu_a", alu_a, 32'h77);
        checkOutput("resume_alu_f", {29'd0, alu_f}, 32'h7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
